// File: rtl/amplifier_mc.sv
// Multi-channel programmable scaler: shared write port, registered multiply stage,
// optional result saturation and an output FIFO with valid/ready backpressure.
module amplifier_mc #(
    parameter int NUM_CH     = 4,
    parameter int NO_W       = 8,
    parameter int DATA_W     = 8,
    parameter int SCALER_W   = 16,
    parameter int RES_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SAT_EN     = 1,
    parameter int SCALER_RST = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    output logic                          wr_ready_o,
    input  logic                          set_scaler_i,
    input  logic [CH_W-1:0]               ch_i,
    input  logic [NO_W+DATA_W-1:0]        wr_data_i,
    output logic                          rd_val_o,
    input  logic                          rd_ready_i,
    output logic [CH_W+NO_W+RES_W-1:0]    rd_data_o,
    output logic [SCALER_W-1:0]           scaler_o,
    output logic                          err_o,
    output logic [15:0]                   sat_cnt_o
);

    localparam int IN_W   = NO_W + DATA_W;
    localparam int PROD_W = DATA_W + SCALER_W;
    localparam int OUT_W  = CH_W + NO_W + RES_W;
    localparam int AW     = $clog2(FIFO_DEPTH);

    logic [SCALER_W-1:0] scaler_q [NUM_CH];

    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic [NO_W-1:0]   s1_no;
    logic [PROD_W-1:0] s1_prod;

    logic [OUT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic              err_q;
    logic [15:0]       sat_cnt_q;

    logic              ch_ok;
    logic              accept;
    logic              acc_data;
    logic              acc_scaler;
    logic [AW+1:0]     credit_used;
    logic [PROD_W-1:0] product;
    logic              over;
    logic [RES_W-1:0]  result;
    logic              sat_event;
    logic              push;
    logic              pop;

    assign ch_ok      = 32'(ch_i) < NUM_CH;
    assign accept     = wr_en_i && wr_ready_o;
    assign acc_data   = accept && ch_ok && !set_scaler_i;
    assign acc_scaler = accept && ch_ok && set_scaler_i;

    // Words in stage 1 already own a FIFO slot, so counting them here guarantees no loss.
    assign credit_used = (AW+2)'(count) + (AW+2)'(s1_valid);
    assign wr_ready_o  = 32'(credit_used) < FIFO_DEPTH;

    assign scaler_o = ch_ok ? scaler_q[ch_i] : '0;
    assign product  = PROD_W'(wr_data_i[DATA_W-1:0]) * PROD_W'(scaler_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scaler_q[i] <= SCALER_W'(SCALER_RST);
            end
        end else if (acc_scaler) begin
            scaler_q[ch_i] <= wr_data_i[SCALER_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= acc_data;
            if (acc_data) begin
                s1_ch   <= ch_i;
                s1_no   <= wr_data_i[IN_W-1:DATA_W];
                s1_prod <= product;
            end
        end
    end

    generate
        if (PROD_W > RES_W) begin : g_over
            assign over = |s1_prod[PROD_W-1:RES_W];
        end else begin : g_no_over
            assign over = 1'b0;
        end
    endgenerate

    assign result    = ((SAT_EN != 0) && over) ? '1 : RES_W'(s1_prod);
    assign sat_event = s1_valid && (SAT_EN != 0) && over;

    assign push = s1_valid;
    assign pop  = rd_val_o && rd_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s1_ch, s1_no, result};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_val_o  = (count != '0);
    assign rd_data_o = rd_val_o ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            err_q <= accept && !ch_ok;
            if (sat_event && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_q <= sat_cnt_q + 16'd1;
            end
        end
    end

    assign err_o     = err_q;
    assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_amplifier_mc.sv
// Self-checking bench for amplifier_mc: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_amplifier_mc;

    localparam int NUM_CH     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = 2;
    localparam int OUT_W      = 26;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic             set_scaler;
    logic [CH_W-1:0]  ch;
    logic [15:0]      wr_data;
    logic             rd_ready;

    logic             wr_ready, wr_ready2;
    logic             rd_val, rd_val2;
    logic [OUT_W-1:0] rd_data, rd_data2;
    logic [15:0]      scaler, scaler2;
    logic             err, err2;
    logic [15:0]      sat_cnt, sat_cnt2;

    amplifier_mc u_dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_ready_o(wr_ready),
        .set_scaler_i(set_scaler), .ch_i(ch), .wr_data_i(wr_data),
        .rd_val_o(rd_val), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .scaler_o(scaler), .err_o(err), .sat_cnt_o(sat_cnt)
    );

    // Truncating variant, driven in lockstep with the saturating one.
    amplifier_mc #(.SAT_EN(0)) u_dut_trunc (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_ready_o(wr_ready2),
        .set_scaler_i(set_scaler), .ch_i(ch), .wr_data_i(wr_data),
        .rd_val_o(rd_val2), .rd_ready_i(rd_ready), .rd_data_o(rd_data2),
        .scaler_o(scaler2), .err_o(err2), .sat_cnt_o(sat_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [OUT_W-1:0] word;
        int               acc_edge;
        bit               sat;
    } item_t;

    item_t       q[$];
    logic [15:0] m_scaler [NUM_CH];
    int          m_sat;
    int          edge_cnt;
    int          errors;
    int          checks;

    logic             exp_wr_ready, exp_rd_val;
    logic [OUT_W-1:0] exp_rd_data;
    logic [15:0]      exp_scaler;
    int               exp_sat;

    logic             s_wr_ready, s_rd_val, s_err, s_err2;
    logic [OUT_W-1:0] s_rd_data, s_rd_data2;
    logic [15:0]      s_scaler, s_sat, s_sat2;

    function automatic void model_result(input logic [1:0] c, input logic [15:0] d,
                                         output logic [OUT_W-1:0] w, output bit s);
        longint unsigned p;
        p = longint'(d[7:0]) * longint'(m_scaler[c]);
        if (p > 65535) begin
            w = {c, d[15:8], 16'hFFFF};
            s = 1'b1;
        end else begin
            w = {c, d[15:8], p[15:0]};
            s = 1'b0;
        end
    endfunction

    // Samples outputs before the edge, then advances the model across one clock edge.
    task automatic step();
        bit               acc;
        bit               pop;
        bit               s;
        logic [OUT_W-1:0] w;
        @(negedge clk);
        exp_wr_ready = (q.size() < FIFO_DEPTH);
        exp_rd_val   = (q.size() > 0) && (q[0].acc_edge < edge_cnt);
        exp_rd_data  = exp_rd_val ? q[0].word : '0;
        exp_scaler   = m_scaler[ch];
        exp_sat      = m_sat;
        s_wr_ready   = wr_ready;
        s_rd_val     = rd_val;
        s_rd_data    = rd_data;
        s_rd_data2   = rd_data2;
        s_scaler     = scaler;
        s_sat        = sat_cnt;
        s_sat2       = sat_cnt2;
        s_err        = err;
        s_err2       = err2;
        acc = (wr_en && wr_ready) === 1'b1;
        pop = (rd_val && rd_ready) === 1'b1;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            q.delete();
            for (int i = 0; i < NUM_CH; i++) m_scaler[i] = 16'd1;
            m_sat = 0;
        end else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            foreach (q[i]) begin
                if (q[i].acc_edge == edge_cnt - 1 && q[i].sat && m_sat < 65535) m_sat++;
            end
            if (acc) begin
                if (set_scaler) begin
                    m_scaler[ch] = wr_data;
                end else begin
                    model_result(ch, wr_data, w, s);
                    q.push_back('{word: w, acc_edge: edge_cnt, sat: s});
                end
            end
        end
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        rd_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch = CH_W'(c);
            step();
            checks += 5;
            if (s_rd_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_val: got %b want 0", s_rd_val); end
            if (s_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready: got %b want 1", s_wr_ready); end
            if (s_sat !== 16'd0) begin errors++; $display("[TB] FAIL reset_sat_cnt: got %0d want 0", s_sat); end
            if (s_scaler !== 16'd1) begin errors++; $display("[TB] FAIL reset_scaler ch%0d: got %0d want 1", c, s_scaler); end
            if (s_rd_data !== '0 || s_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_err: data %h err %b want 0", s_rd_data, s_err); end
        end
    endtask

    task automatic test_scaler_basic();
        rd_ready = 1'b0;
        wr_en = 1'b1; set_scaler = 1'b1; ch = 2'd2; wr_data = 16'd55;
        step();
        set_scaler = 1'b0; wr_data = {8'h07, 8'd3};
        step();
        checks += 2;
        if (s_scaler !== 16'd55) begin errors++; $display("[TB] FAIL scaler_readback: got %0d want 55", s_scaler); end
        if (s_wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_wr_ready: got %b want 1", s_wr_ready); end
        wr_en = 1'b0;
        step();
        checks++;
        if (s_rd_val !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b want 0", s_rd_val); end
        rd_ready = 1'b1;
        step();
        checks += 2;
        if (s_rd_val !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b want 1", s_rd_val); end
        if (s_rd_data !== {2'd2, 8'h07, 16'd165}) begin errors++; $display("[TB] FAIL basic_data: got %h want %h", s_rd_data, {2'd2, 8'h07, 16'd165}); end
        step();
        checks++;
        if (s_rd_val !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained: got %b want 0", s_rd_val); end
        rd_ready = 1'b0;
    endtask

    task automatic test_mult();
        rd_ready = 1'b1;
        wr_en = 1'b1; set_scaler = 1'b1; ch = 2'd1; wr_data = 16'd5;
        step();
        set_scaler = 1'b0; wr_data = {8'h3C, 8'd123};
        step();
        wr_en = 1'b0;
        step();
        step();
        checks += 2;
        if (s_rd_val !== 1'b1) begin errors++; $display("[TB] FAIL mult_valid: got %b want 1", s_rd_val); end
        if (s_rd_data !== {2'd1, 8'h3C, 16'd615}) begin errors++; $display("[TB] FAIL mult_data: got %h want %h", s_rd_data, {2'd1, 8'h3C, 16'd615}); end
    endtask

    task automatic test_saturation();
        rd_ready = 1'b1;
        wr_en = 1'b1; set_scaler = 1'b1; ch = 2'd0; wr_data = 16'h0400;
        step();
        set_scaler = 1'b0; wr_data = {8'h11, 8'hFF};
        step();
        wr_en = 1'b0;
        step();
        step();
        checks += 4;
        if (s_rd_data !== {2'd0, 8'h11, 16'hFFFF}) begin errors++; $display("[TB] FAIL sat_data: got %h want %h", s_rd_data, {2'd0, 8'h11, 16'hFFFF}); end
        if (s_sat !== 16'd1) begin errors++; $display("[TB] FAIL sat_cnt: got %0d want 1", s_sat); end
        if (s_rd_data2 !== {2'd0, 8'h11, 16'hFC00}) begin errors++; $display("[TB] FAIL trunc_data: got %h want %h", s_rd_data2, {2'd0, 8'h11, 16'hFC00}); end
        if (s_sat2 !== 16'd0) begin errors++; $display("[TB] FAIL trunc_sat_cnt: got %0d want 0", s_sat2); end
    endtask

    task automatic test_backpressure();
        logic [15:0]      bp_data [6];
        logic [1:0]       bp_ch [6];
        logic [OUT_W-1:0] bp_exp [6];
        bit               s;
        int               idx;
        int               got;
        for (int k = 0; k < 6; k++) begin
            bp_ch[k]   = 2'(k);
            bp_data[k] = {8'h40 + 8'(k), 8'($urandom_range(0, 255))};
            model_result(bp_ch[k], bp_data[k], bp_exp[k], s);
        end
        idx = 0;
        rd_ready = 1'b0;
        set_scaler = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wr_en = 1'b1; ch = bp_ch[idx]; wr_data = bp_data[idx];
            step();
            checks++;
            if (s_wr_ready !== (k < 4)) begin errors++; $display("[TB] FAIL bp_wr_ready step%0d: got %b want %b", k, s_wr_ready, k < 4); end
            if (s_wr_ready === 1'b1) idx++;
        end
        checks++;
        if (s_rd_val !== 1'b1) begin errors++; $display("[TB] FAIL bp_full_valid: got %b want 1", s_rd_val); end
        rd_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 30 && got < 6; t++) begin
            wr_en = (idx < 6);
            if (idx < 6) begin ch = bp_ch[idx]; wr_data = bp_data[idx]; end
            step();
            if (wr_en && s_wr_ready === 1'b1) idx++;
            if (s_rd_val === 1'b1) begin
                checks++;
                if (s_rd_data !== bp_exp[got]) begin errors++; $display("[TB] FAIL bp_order #%0d: got %h want %h", got, s_rd_data, bp_exp[got]); end
                got++;
            end
        end
        wr_en = 1'b0;
        checks++;
        if (got != 6) begin errors++; $display("[TB] FAIL bp_count: got %0d results want 6", got); end
        step();
        checks++;
        if (s_rd_val !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %b want 0", s_rd_val); end
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b0;
        set_scaler = 1'b0;
        wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ch = 2'(k); wr_data = {8'h80 + 8'(k), 8'd9};
            step();
        end
        wr_en = 1'b0;
        step();
        rd_ready = 1'b1;
        rst = 1'b1;
        step();
        checks++;
        if (s_rd_val !== 1'b1) begin errors++; $display("[TB] FAIL mid_queued: got %b want 1", s_rd_val); end
        rst = 1'b0;
        rd_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch = CH_W'(c);
            step();
            checks += 3;
            if (s_rd_val !== 1'b0) begin errors++; $display("[TB] FAIL mid_rd_val: got %b want 0", s_rd_val); end
            if (s_scaler !== 16'd1) begin errors++; $display("[TB] FAIL mid_scaler ch%0d: got %0d want 1", c, s_scaler); end
            if (s_sat !== 16'd0) begin errors++; $display("[TB] FAIL mid_sat_cnt: got %0d want 0", s_sat); end
        end
        test_scaler_basic();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en      = ($urandom_range(0, 3) != 0);
            set_scaler = ($urandom_range(0, 7) == 0);
            ch         = 2'($urandom_range(0, NUM_CH - 1));
            wr_data    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 600)) : 16'($urandom);
            rd_ready   = ($urandom_range(0, 3) != 0);
            step();
            checks += 6;
            if (s_wr_ready !== exp_wr_ready) begin errors++; $display("[TB] FAIL rnd_wr_ready @%0d: got %b want %b", n, s_wr_ready, exp_wr_ready); end
            if (s_rd_val !== exp_rd_val) begin errors++; $display("[TB] FAIL rnd_rd_val @%0d: got %b want %b", n, s_rd_val, exp_rd_val); end
            if (s_rd_data !== exp_rd_data) begin errors++; $display("[TB] FAIL rnd_rd_data @%0d: got %h want %h", n, s_rd_data, exp_rd_data); end
            if (s_scaler !== exp_scaler) begin errors++; $display("[TB] FAIL rnd_scaler @%0d: got %h want %h", n, s_scaler, exp_scaler); end
            if (s_sat !== 16'(exp_sat)) begin errors++; $display("[TB] FAIL rnd_sat_cnt @%0d: got %0d want %0d", n, s_sat, exp_sat); end
            if (s_err !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err @%0d: got %b want 0", n, s_err); end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        edge_cnt = 0;
        m_sat = 0;
        for (int i = 0; i < NUM_CH; i++) m_scaler[i] = 16'd1;
        rst = 1'b1;
        wr_en = 1'b0;
        set_scaler = 1'b0;
        ch = '0;
        wr_data = '0;
        rd_ready = 1'b0;
        $display("[TB] starting amplifier_mc bench");
        test_reset();
        test_scaler_basic();
        test_mult();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
